// File: rtl/inst_fetch_buffer.sv
// Dual-issue circular instruction queue between fetch and decode.
// Accepts up to two pc/inst pairs per cycle and presents the two oldest.
module inst_fetch_buffer #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 32,
    parameter int INST_W = 32,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              in_valid_1_i,
    input  logic              in_valid_2_i,
    input  logic [ADDR_W-1:0] in_pc_1_i,
    input  logic [ADDR_W-1:0] in_pc_2_i,
    input  logic [INST_W-1:0] in_inst_1_i,
    input  logic [INST_W-1:0] in_inst_2_i,
    input  logic [1:0]        deq_num_i,
    output logic              out_valid_1_o,
    output logic              out_valid_2_o,
    output logic [ADDR_W-1:0] out_pc_1_o,
    output logic [ADDR_W-1:0] out_pc_2_o,
    output logic [INST_W-1:0] out_inst_1_o,
    output logic [INST_W-1:0] out_inst_2_o,
    output logic              fetch_pause_o,
    output logic [CW-1:0]     count_o,
    output logic              overflow_o
);

    logic [PW-1:0]     head_ptr;
    logic [PW-1:0]     tail_ptr;
    logic [CW-1:0]     count;
    logic              overflow;

    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic [INST_W-1:0] inst_mem [DEPTH];

    logic [CW-1:0]     free;
    logic [1:0]        deq_req;
    logic [1:0]        eff_deq;
    logic [1:0]        n_wr;
    logic              wr_1;
    logic              wr_2;
    logic              drop;
    logic [PW-1:0]     wr_2_ptr;
    logic [PW-1:0]     head_nxt;

    // Room is judged on pre-dequeue occupancy; older slot wins.
    always_comb begin
        free    = CW'(DEPTH) - count;
        deq_req = (deq_num_i == 2'd3) ? 2'd2 : deq_num_i;
        eff_deq = deq_req;
        if (CW'(deq_req) > count) begin
            eff_deq = count[1:0];
        end
        wr_1 = in_valid_1_i && (free != '0);
        wr_2 = in_valid_2_i &&
               (in_valid_1_i ? (free >= CW'(2))
                             : (free != '0));
        drop = (in_valid_1_i && !wr_1) ||
               (in_valid_2_i && !wr_2);
        n_wr = {1'b0, wr_1} + {1'b0, wr_2};
        wr_2_ptr = wr_1 ? tail_ptr + PW'(1) : tail_ptr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (flush_i) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            head_ptr <= head_ptr + PW'(eff_deq);
            tail_ptr <= tail_ptr + PW'(n_wr);
            count    <= count + CW'(n_wr) - CW'(eff_deq);
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // Storage has no reset; occupancy alone defines validity.
    always_ff @(posedge clk) begin
        if (!rst && !flush_i) begin
            if (wr_1) begin
                pc_mem[tail_ptr]   <= in_pc_1_i;
                inst_mem[tail_ptr] <= in_inst_1_i;
            end
            if (wr_2) begin
                pc_mem[wr_2_ptr]   <= in_pc_2_i;
                inst_mem[wr_2_ptr] <= in_inst_2_i;
            end
        end
    end

    always_comb begin
        head_nxt      = head_ptr + PW'(1);
        out_valid_1_o = (count >= CW'(1));
        out_valid_2_o = (count >= CW'(2));
        out_pc_1_o    = '0;
        out_inst_1_o  = '0;
        out_pc_2_o    = '0;
        out_inst_2_o  = '0;
        if (out_valid_1_o) begin
            out_pc_1_o   = pc_mem[head_ptr];
            out_inst_1_o = inst_mem[head_ptr];
        end
        if (out_valid_2_o) begin
            out_pc_2_o   = pc_mem[head_nxt];
            out_inst_2_o = inst_mem[head_nxt];
        end
        fetch_pause_o = (count > CW'(DEPTH - 4));
        count_o       = count;
        overflow_o    = overflow;
    end

endmodule
